// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two masters, the arbiter and the data memory.
// Handshake: a master holds reqN high to ask for the bus; an access is
// accepted in every cycle where reqN & gntN are both high, one per cycle.
// Read data returns one cycle after acceptance with a single-cycle rvalidN.
// The master modport belongs to the masters and memory side; the slave
// modport belongs to the arbiter.
interface mem_bus_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0;
  logic        rvalid1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadData,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           MemWrite, DataAdr, WriteData
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadData,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           MemWrite, DataAdr, WriteData
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a single data-memory port.
// M0 is the core, M1 the debug/DMA agent. An owner keeps the bus for up to
// MAX_BURST accepted accesses while the other master waits, then ownership
// rotates without a bubble. Memory reads are combinational; read data is
// registered back to the requester one cycle after acceptance.
// Optional feature macro: ARB_STATS_EN adds grants0/grants1/wait_cycles
// saturating counters. dbg_state exposes the FSM state (0 IDLE, 1 OWN0,
// 2 OWN1).
module mem_bus_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus,
  output logic [1:0]        dbg_state
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grants0,
  output logic [CNT_W-1:0]  grants1,
  output logic [CNT_W-1:0]  wait_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;
  logic          acc0, acc1;
  logic          enter0, enter1;

  // Accepted accesses this cycle; grant flops mirror the owned state.
  assign acc0 = bus.req0 & gnt0_q;
  assign acc1 = bus.req1 & gnt1_q;

  // Next ownership, burst count and tie-break memory.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (bus.req0) begin
          state_d = OWN0;
        end else if (bus.req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          state_d = bus.req1 ? OWN1 : IDLE;
        end else begin
          // Burst saturates so a lone owner keeps the bus indefinitely.
          if (burst_q != BURST_LAST) burst_d = burst_q + BW'(1);
          if (bus.req1 && (burst_q == BURST_LAST)) state_d = OWN1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_d = bus.req0 ? OWN0 : IDLE;
        end else begin
          if (burst_q != BURST_LAST) burst_d = burst_q + BW'(1);
          if (bus.req0 && (burst_q == BURST_LAST)) state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase
    enter0 = (state_d == OWN0) && (state_q != OWN0);
    enter1 = (state_d == OWN1) && (state_q != OWN1);
    // A fresh tenure restarts the burst and records who went last.
    if (enter0) begin
      last_d  = 1'b0;
      burst_d = '0;
    end else if (enter1) begin
      last_d  = 1'b1;
      burst_d = '0;
    end
    gnt0_d = (state_d == OWN0);
    gnt1_d = (state_d == OWN1);
  end

  // Read return: capture memory data for an accepted read, else hold.
  always_comb begin
    rvalid0_d = acc0 & ~bus.we0;
    rvalid1_d = acc1 & ~bus.we1;
    rdata0_d  = rvalid0_d ? bus.ReadData : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.ReadData : rdata1_q;
  end

  // Arbiter state and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      burst_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Memory port follows the owner only; a non-owner never reaches memory.
  always_comb begin
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
    bus.WriteData = '0;
    if (gnt0_q) begin
      bus.MemWrite  = bus.req0 & bus.we0;
      bus.DataAdr   = bus.addr0;
      bus.WriteData = bus.wdata0;
    end else if (gnt1_q) begin
      bus.MemWrite  = bus.req1 & bus.we1;
      bus.DataAdr   = bus.addr1;
      bus.WriteData = bus.wdata1;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign dbg_state   = state_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] grants0_q, grants0_d;
  logic [CNT_W-1:0] grants1_q, grants1_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  // Saturating statistics: tenure entries and cycles with a waiting master.
  always_comb begin
    grants0_d = grants0_q;
    grants1_d = grants1_q;
    wait_d    = wait_q;
    if (enter0 && (grants0_q != '1)) grants0_d = grants0_q + CNT_W'(1);
    if (enter1 && (grants1_q != '1)) grants1_d = grants1_q + CNT_W'(1);
    if (((bus.req0 & ~gnt0_q) | (bus.req1 & ~gnt1_q)) && (wait_q != '1))
      wait_d = wait_q + CNT_W'(1);
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grants0_q <= '0;
      grants1_q <= '0;
      wait_q    <= '0;
    end else begin
      grants0_q <= grants0_d;
      grants1_q <= grants1_d;
      wait_q    <= wait_d;
    end
  end

  assign grants0     = grants0_q;
  assign grants1     = grants1_q;
  assign wait_cycles = wait_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all checked against a tenure-level reference model.
module tb_mem_bus_arbiter;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 16;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();
  logic [1:0] dbg_state;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] grants0, grants1, wait_cycles;
`endif

  mem_bus_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef ARB_STATS_EN
    ,
    .grants0     (grants0),
    .grants1     (grants1),
    .wait_cycles (wait_cycles)
`endif
  );

  // Combinational memory behind the arbiter
  logic [31:0] tb_mem [64];
  assign bus.ReadData = tb_mem[bus.DataAdr[7:2]];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the bus and how many accesses this tenure made
  int          m_owner = -1;
  int          m_last  = 1;
  int          m_count = 0;
  bit          m_known = 0;
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  longint      m_gr0, m_gr1, m_wc;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  function automatic longint sat_inc(input longint v);
    return (v >= (64'd1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  // Driver
  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  // One clock: check memory port, advance the model, check registered outputs
  task automatic cycle();
    logic        r[2], w[2];
    logic [31:0] a[2], d[2];
    logic        e_mw;
    logic [31:0] e_adr, e_wd, popped;
    int          nxt, x, y;
    r[0] = bus.req0; w[0] = bus.we0; a[0] = bus.addr0; d[0] = bus.wdata0;
    r[1] = bus.req1; w[1] = bus.we1; a[1] = bus.addr1; d[1] = bus.wdata1;
    #2;
    if (m_known) begin
      e_mw = 1'b0; e_adr = '0; e_wd = '0;
      if (m_owner >= 0) begin
        e_mw = r[m_owner] & w[m_owner]; e_adr = a[m_owner]; e_wd = d[m_owner];
      end
      check_eq("MemWrite", {31'd0, bus.MemWrite}, {31'd0, e_mw});
      check_eq("DataAdr", bus.DataAdr, e_adr);
      check_eq("WriteData", bus.WriteData, e_wd);
    end
    m_rv0 = 1'b0; m_rv1 = 1'b0;
    if (!reset) begin
      m_owner = -1; m_last = 1; m_count = 0; m_known = 1;
      m_rd0 = '0; m_rd1 = '0; m_gr0 = 0; m_gr1 = 0; m_wc = 0;
      exp_q0.delete(); exp_q1.delete();
    end else begin
      if ((r[0] && m_owner != 0) || (r[1] && m_owner != 1)) m_wc = sat_inc(m_wc);
      if (m_owner < 0) begin
        if (r[0] && r[1]) nxt = 1 - m_last;
        else if (r[0])    nxt = 0;
        else if (r[1])    nxt = 1;
        else              nxt = -1;
      end else begin
        x = m_owner; y = 1 - x;
        if (r[x]) begin
          if (!w[x]) begin
            if (x == 0) begin m_rv0 = 1'b1; m_rd0 = tb_mem[a[x][7:2]]; exp_q0.push_back(m_rd0); end
            else        begin m_rv1 = 1'b1; m_rd1 = tb_mem[a[x][7:2]]; exp_q1.push_back(m_rd1); end
          end
          nxt = (r[y] && m_count >= MAX_BURST - 1) ? y : x;
          m_count++;
        end else begin
          nxt = r[y] ? y : -1;
        end
      end
      if (nxt >= 0 && nxt != m_owner) begin
        m_last = nxt; m_count = 0;
        if (nxt == 0) m_gr0 = sat_inc(m_gr0); else m_gr1 = sat_inc(m_gr1);
      end
      m_owner = nxt;
    end
    @(posedge clk); #1;
    check_eq("gnt0", {31'd0, bus.gnt0}, {31'd0, m_owner == 0});
    check_eq("gnt1", {31'd0, bus.gnt1}, {31'd0, m_owner == 1});
    check_eq("gnt_excl", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
    check_eq("dbg_idle", {31'd0, dbg_state == 2'd0}, {31'd0, m_owner == -1});
    check_eq("rvalid0", {31'd0, bus.rvalid0}, {31'd0, m_rv0});
    check_eq("rvalid1", {31'd0, bus.rvalid1}, {31'd0, m_rv1});
    check_eq("rdata0", bus.rdata0, m_rd0);
    check_eq("rdata1", bus.rdata1, m_rd1);
    if (m_rv0 && exp_q0.size() > 0) begin popped = exp_q0.pop_front(); check_eq("sb_rdata0", bus.rdata0, popped); end
    if (m_rv1 && exp_q1.size() > 0) begin popped = exp_q1.pop_front(); check_eq("sb_rdata1", bus.rdata1, popped); end
`ifdef ARB_STATS_EN
    check_eq("grants0", {{(32-CNT_W){1'b0}}, grants0}, 32'(m_gr0));
    check_eq("grants1", {{(32-CNT_W){1'b0}}, grants1}, 32'(m_gr1));
    check_eq("wait_cycles", {{(32-CNT_W){1'b0}}, wait_cycles}, 32'(m_wc));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  // Stimulus and report
  initial begin
    for (int i = 0; i < 64; i++) tb_mem[i] = $urandom;
    tb_mem[16] = 32'hDEADBEEF;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset held with a pending request, then grant on release
    reset = 1'b0;
    cycle();
    cycle();
    check_eq("t1_gnt0_in_reset", {31'd0, bus.gnt0}, 32'd0);
    reset = 1'b1;
    cycle();
    check_eq("t1_gnt0_after", {31'd0, bus.gnt0}, 32'd1);

    // Tie from IDLE goes to M0; three reads, then drop hands over to M1
    do_reset();
    drive(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
    cycle();
    check_eq("t2_first_gnt0", {31'd0, bus.gnt0}, 32'd1);
    for (int i = 0; i < 3; i++) cycle();
    bus.req0 = 1'b0;
    cycle();
    check_eq("t2_handover_gnt1", {31'd0, bus.gnt1}, 32'd1);

    // Both masters streaming: rotation every MAX_BURST accesses
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
            1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      cycle();
    end

    // M1 read of 0x40 returns DEADBEEF
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    cycle();
    cycle();
    check_eq("t4_rvalid1", {31'd0, bus.rvalid1}, 32'd1);
    check_eq("t4_rdata1", bus.rdata1, 32'hDEADBEEF);
    check_eq("t4_rvalid0", {31'd0, bus.rvalid0}, 32'd0);

    // M0 writing while M1 waits with a write to 0x80
    do_reset();
    drive(1'b1, 1'b1, 32'h10, 32'h1111, 1'b1, 1'b1, 32'h80, 32'h2222);
    for (int i = 0; i < 10; i++) cycle();

    // Randomized traffic with occasional mid-burst reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
      reset = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
